// File: rtl/hvsync_generator.sv
// VGA-style horizontal/vertical timing generator: free-running pixel/line counters with sync and blanking decodes.
// Define HVSYNC_POSITIVE_SYNC_EN to make hsync/vsync active-high (default build: active-low).
module hvsync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       hsync_act;
    logic       vsync_act;

    // vpos advances only on the line wrap, so both counters wrap together at end of frame
    always_comb begin
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (hpos_q == H_LAST) begin
            hpos_d = 10'd0;
            if (vpos_q == V_LAST) begin
                vpos_d = 10'd0;
            end else begin
                vpos_d = vpos_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos_q <= 10'd0;
            vpos_q <= 10'd0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
        end
    end

    assign hsync_act  = (hpos_q >= H_SYNC_BEG) && (hpos_q < H_SYNC_END);
    assign vsync_act  = (vpos_q >= V_SYNC_BEG) && (vpos_q < V_SYNC_END);
    assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign hpos       = hpos_q;
    assign vpos       = vpos_q;

`ifdef HVSYNC_POSITIVE_SYNC_EN
    assign hsync = hsync_act;
    assign vsync = vsync_act;
`else
    assign hsync = ~hsync_act;
    assign vsync = ~vsync_act;
`endif

endmodule

// File: tb/tb_hvsync_generator.sv
// Self-checking bench for hvsync_generator: default-size instance for line timing, a shrunken instance for frame timing.
module tb_hvsync_generator;

`ifdef HVSYNC_POSITIVE_SYNC_EN
    localparam logic ACT = 1'b1;
`else
    localparam logic ACT = 1'b0;
`endif

    // shrunken geometry: H_TOTAL=15 (sync 10..12), V_TOTAL=13 (sync lines 8..9), frame=195 clocks
    localparam int SH_DISP = 8, SH_FRONT = 2, SH_SYNC = 3, SH_BACK = 2;
    localparam int SV_DISP = 6, SV_FRONT = 2, SV_SYNC = 2, SV_BACK = 3;
    localparam int SH_TOT  = 15, SV_TOT = 13;

    logic       clk;
    logic       rst_n;
    logic       rst_s_n;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;
    logic       hsync_s, vsync_s, display_on_s;
    logic [9:0] hpos_s, vpos_s;

    int n_checks = 0;
    int n_err    = 0;

    hvsync_generator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos)
    );

    hvsync_generator #(
        .H_DISPLAY (SH_DISP), .H_FRONT (SH_FRONT), .H_SYNC (SH_SYNC), .H_BACK (SH_BACK),
        .V_DISPLAY (SV_DISP), .V_FRONT (SV_FRONT), .V_SYNC (SV_SYNC), .V_BACK (SV_BACK)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_s_n),
        .hsync      (hsync_s),
        .vsync      (vsync_s),
        .display_on (display_on_s),
        .hpos       (hpos_s),
        .vpos       (vpos_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        int         ncyc;
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       hs_on;
        logic       vs_on;
        logic       de;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic pol(input logic on);
        return on ? ACT : ~ACT;
    endfunction

    int hs_cnt, vs_cnt, de_bad, eh, ev;

    initial begin
        // {rst_n, clocks, hpos, vpos, hsync asserted, vsync asserted, display_on}
        vecs[0]  = '{1'b0, 1,   10'd0,   10'd0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1,   10'd1,   10'd0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 638, 10'd639, 10'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1,   10'd640, 10'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 15,  10'd655, 10'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1,   10'd656, 10'd0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 95,  10'd751, 10'd0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1,   10'd752, 10'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 47,  10'd799, 10'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1,   10'd0,   10'd1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 300, 10'd0,   10'd0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1,   10'd1,   10'd0, 1'b0, 1'b0, 1'b1};

        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            // vector 10 runs 299 clocks in-line, then reset takes effect on its last edge
            if (i == 10) begin
                rst_n = 1'b1;
                step(299);
                chk("pre_reset_hpos", hpos, 299);
                rst_n = 1'b0;
                step(1);
            end else begin
                rst_n = vecs[i].rst_n;
                step(vecs[i].ncyc);
            end
            chk($sformatf("vec%0d_hpos", i), hpos, vecs[i].hpos);
            chk($sformatf("vec%0d_vpos", i), vpos, vecs[i].vpos);
            chk($sformatf("vec%0d_hsync", i), hsync, pol(vecs[i].hs_on));
            chk($sformatf("vec%0d_vsync", i), vsync, pol(vecs[i].vs_on));
            chk($sformatf("vec%0d_de", i), display_on, vecs[i].de);
        end

        // one full default line from reset, every clock
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        hs_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            chk("line_hpos", hpos, i);
            chk("line_vpos", vpos, 0);
            chk("line_hsync", hsync, pol(i >= 656 && i < 752));
            chk("line_de", display_on, (i < 640) ? 1 : 0);
            if (hsync == ACT) hs_cnt++;
            step(1);
        end
        chk("line_hsync_width", hs_cnt, 96);
        chk("line_wrap_hpos", hpos, 0);
        chk("line_wrap_vpos", vpos, 1);

        // shrunken frame from reset, every clock
        rst_s_n = 1'b1;
        vs_cnt = 0;
        de_bad = 0;
        for (int i = 0; i < SH_TOT * SV_TOT; i++) begin
            eh = i % SH_TOT;
            ev = i / SH_TOT;
            chk("frame_hpos", hpos_s, eh);
            chk("frame_vpos", vpos_s, ev);
            chk("frame_hsync", hsync_s, pol(eh >= 10 && eh < 13));
            chk("frame_vsync", vsync_s, pol(ev >= 8 && ev < 10));
            chk("frame_de", display_on_s, (eh < 8 && ev < 6) ? 1 : 0);
            if (vsync_s == ACT) vs_cnt++;
            if (ev >= 6 && display_on_s) de_bad++;
            step(1);
        end
        chk("frame_vsync_clocks", vs_cnt, 2 * SH_TOT);
        chk("frame_de_blank_lines", de_bad, 0);
        chk("frame_end_hpos", hpos_s, 0);
        chk("frame_end_vpos", vpos_s, 0);

        // last pixel of the frame, then one clock
        step(SH_TOT * SV_TOT - 1);
        chk("last_hpos", hpos_s, 14);
        chk("last_vpos", vpos_s, 12);
        step(1);
        chk("wrap_hpos", hpos_s, 0);
        chk("wrap_vpos", vpos_s, 0);

        // mid-frame reset at (7,4)
        step(4 * SH_TOT + 7);
        chk("mid_hpos", hpos_s, 7);
        chk("mid_vpos", vpos_s, 4);
        rst_s_n = 1'b0;
        step(1);
        chk("mid_rst_hpos", hpos_s, 0);
        chk("mid_rst_vpos", vpos_s, 0);
        rst_s_n = 1'b1;
        step(1);
        chk("mid_rel_hpos", hpos_s, 1);
        chk("mid_rel_vpos", vpos_s, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
